// File: rtl/fft_pkg.sv
// fft_pkg: shared Q1.15 format constants and packed-operand slicing helper
package fft_pkg;
  localparam int DW = 16;
  localparam int FRAC = DW - 1;
  localparam int MAX_REQ = 8;
  localparam logic [DW-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DW-1:0] Q_MIN = 16'h8000;
  function automatic logic [DW-1:0] op_slice(input logic [MAX_REQ*DW-1:0] bus, input int i);
    return bus[i*DW +: DW];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from the last accepted winner
module rr_arbiter
  import fft_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic hit;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    cand = '0;
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    grant[idx] = hit && adv && !rst;
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (hit && adv) ptr <= idx;
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin shared 2-stage Q1.15 multiplier.
// MULT_SHARE_SAT_EN saturates (-1.0)*(-1.0) to +max instead of wrapping.
module mult_share_arbiter
  import fft_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = fft_pkg::DW,
  parameter int TAGW = 4,
  localparam int IDW = $clog2(NREQ)
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_din,
  input  logic [NREQ*DW-1:0]   req_w,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_dout,
  output logic [IDW-1:0]       out_id,
  output logic [TAGW-1:0]      out_tag,
  output logic                 busy
);
  logic adv;
  logic s1_valid;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] s1_id;
  logic [DW-1:0] s1_din;
  logic [DW-1:0] s1_w;
  logic [DW-1:0] dout_n;
  logic [TAGW-1:0] s1_tag;
  logic [MAX_REQ*DW-1:0] din_bus;
  logic [MAX_REQ*DW-1:0] w_bus;
  logic signed [2*DW-1:0] prod;
  assign adv = !out_valid || out_ready;
  assign req_ready = grant;
  assign busy = s1_valid || out_valid;
  assign din_bus = (MAX_REQ*DW)'(req_din);
  assign w_bus = (MAX_REQ*DW)'(req_w);
  assign prod = $signed(s1_din) * $signed(s1_w);
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .adv   (adv),
    .grant (grant),
    .idx   (gidx)
  );
  always_comb begin
`ifdef MULT_SHARE_SAT_EN
    dout_n = (s1_din == Q_MIN && s1_w == Q_MIN) ? Q_MAX : prod[FRAC +: DW];
`else
    dout_n = prod[FRAC +: DW];
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_din <= '0;
      s1_w <= '0;
      s1_id <= '0;
      s1_tag <= '0;
      out_valid <= 1'b0;
      out_dout <= '0;
      out_id <= '0;
      out_tag <= '0;
    end else if (adv) begin
      s1_valid <= |grant;
      s1_din <= op_slice(din_bus, int'(gidx));
      s1_w <= op_slice(w_bus, int'(gidx));
      s1_id <= gidx;
      s1_tag <= req_tag[int'(gidx)*TAGW +: TAGW];
      out_valid <= s1_valid;
      out_dout <= dout_n;
      out_id <= s1_id;
      out_tag <= s1_tag;
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench for the shared multiplier
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 16;
  localparam int TAGW = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*DW-1:0] req_din = '0;
  logic [NREQ*DW-1:0] req_w = '0;
  logic [NREQ*TAGW-1:0] req_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_dout;
  logic [IDW-1:0] out_id;
  logic [TAGW-1:0] out_tag;
  logic busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .req_w     (req_w),
    .req_tag   (req_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dout  (out_dout),
    .out_id    (out_id),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NREQ; i++) begin
      req_din[i*DW +: DW] = 16'(i + 1) << 12;
      req_w[i*DW +: DW] = 16'h4000;
      req_tag[i*TAGW +: TAGW] = 4'(i + 8);
    end
    req_valid = '1;
  endtask

  task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TAGW-1:0] t, output bit ok);
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_din[i*DW +: DW] = a;
    req_w[i*DW +: DW] = b;
    req_tag[i*TAGW +: TAGW] = t;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1 ok = (req_ready == (4'(1) << i));
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", out_dout); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", out_id); end
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", out_tag); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    issue(2, 16'h4000, 16'h4000, 4'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept got timeout exp ready"); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_dout !== 16'h2000) begin errors++; $display("FAIL single_dout got %h exp 2000", out_dout); end
    checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d exp 2", out_id); end
    checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL single_tag got %0d exp 5", out_tag); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
  endtask

  task automatic run_vectors(input string name, input logic [DW-1:0] a [4], input logic [DW-1:0] b [4],
                             input logic [DW-1:0] e [4], input int n);
    bit ok;
    bit got;
    for (int k = 0; k < n; k++) begin
      issue(k % NREQ, a[k], b[k], 4'(k + 1), ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s_accept%0d got timeout exp ready", name, k); end
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        got = out_valid;
      end
      checks++; if (!got) begin errors++; $display("FAIL %s_valid%0d got timeout exp out_valid", name, k); end
      checks++; if (out_dout !== e[k]) begin errors++; $display("FAIL %s_dout%0d got %h exp %h", name, k, out_dout, e[k]); end
      checks++; if (out_id !== 2'(k % NREQ)) begin errors++; $display("FAIL %s_id%0d got %0d exp %0d", name, k, out_id, k % NREQ); end
      checks++; if (out_tag !== 4'(k + 1)) begin errors++; $display("FAIL %s_tag%0d got %0d exp %0d", name, k, out_tag, k + 1); end
    end
  endtask

  task automatic test_signs();
    logic [DW-1:0] a [4] = '{16'h4000, 16'hC000, 16'h0001, 16'h4000};
    logic [DW-1:0] b [4] = '{16'hC000, 16'hC000, 16'hFFFF, 16'h4000};
    logic [DW-1:0] e [4] = '{16'hE000, 16'h2000, 16'hFFFF, 16'h2000};
    run_vectors("signs", a, b, e, 4);
  endtask

  task automatic test_corner();
    logic [DW-1:0] a [4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h0000};
    logic [DW-1:0] b [4] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000};
`ifdef MULT_SHARE_SAT_EN
    logic [DW-1:0] e [4] = '{16'h7FFF, 16'h8001, 16'h8001, 16'h0000};
`else
    logic [DW-1:0] e [4] = '{16'h8000, 16'h8001, 16'h8001, 16'h0000};
`endif
    run_vectors("corner", a, b, e, 3);
  endtask

  task automatic test_fairness();
    int ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    reset_dut();
    load_all();
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        checks++; if (req_ready !== (4'(1) << ord[c])) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", c, req_ready, 4'(1) << ord[c]); end
      end
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fair_valid%0d got %b exp 1", c, out_valid); end
        checks++; if (out_id !== 2'(ord[c-2])) begin errors++; $display("FAIL fair_id%0d got %0d exp %0d", c, out_id, ord[c-2]); end
        checks++; if (out_dout !== (16'(ord[c-2] + 1) << 11)) begin errors++; $display("FAIL fair_dout%0d got %h exp %h", c, out_dout, 16'(ord[c-2] + 1) << 11); end
        checks++; if (out_tag !== 4'(ord[c-2] + 8)) begin errors++; $display("FAIL fair_tag%0d got %0d exp %0d", c, out_tag, ord[c-2] + 8); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_stall();
    int exp_id [9] = '{0, 0, 1, 1, 1, 1, 2, 3, 0};
    logic [3:0] exp_rdy [9] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    reset_dut();
    load_all();
    for (int c = 0; c < 9; c++) begin
      if (c == 2) out_ready = 1'b0;
      if (c == 5) out_ready = 1'b1;
      if (c == 6) req_valid = '0;
      #1;
      checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_ready%0d got %b exp %b", c, req_ready, exp_rdy[c]); end
      if (c >= 2 && c < 8) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b exp 1", c, out_valid); end
        checks++; if (out_id !== 2'(exp_id[c])) begin errors++; $display("FAIL bp_id%0d got %0d exp %0d", c, out_id, exp_id[c]); end
        checks++; if (out_dout !== (16'(exp_id[c] + 1) << 11)) begin errors++; $display("FAIL bp_dout%0d got %h exp %h", c, out_dout, 16'(exp_id[c] + 1) << 11); end
        checks++; if (out_tag !== 4'(exp_id[c] + 8)) begin errors++; $display("FAIL bp_tag%0d got %0d exp %0d", c, out_tag, exp_id[c] + 8); end
      end
      if (c == 8) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", busy); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    load_all();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got busy=%b valid=%b exp 1 1", busy, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (out_dout !== 16'h0000) begin errors++; $display("FAIL mid_dout got %h exp 0000", out_dout); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr got %b exp 0010", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b exp 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signs();
    test_corner();
    test_fairness();
    test_back_to_back_stall();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
